dev_bus_arbiter: RTL and testbench
==================================

// Module: dev_bus_arbiter
// PURPOSE
//  Shares the single device bus (the devctrl request port) between two bus masters:
//  m0 = CPU memory port, m1 = DMA/copy engine (e.g. flash->DDR3 loader).
//  Round-robin grant; each transaction is held to completion (devBusy_i low).
//  A watchdog aborts hung transactions.
//  Sits between the masters and devctrl; the device side is a drop-in for the CPU's dev* signals.
// PARAMETERS
//  TIMEOUT_CYCLES  4096          max OWN cycles with devBusy_i high before abort; 0 = watchdog disabled
//  TIMEOUT_DATA    32'hDEADBEEF  value returned on mX_dataLoad_o for an aborted transaction
// PORTS
//  clk               in   1   system clock (clkMain domain)
//  rst_n             in   1   asynchronous active-low reset
//  mX_enable_i       in   1   X=0,1: request; held high with stable fields until mX_busy_o low
//  mX_write_i        in   1   1 = store, 0 = load
//  mX_addr_i         in   32  physical address
//  mX_dataSave_i     in   32  store data
//  mX_byteSelect_i   in   4   byte lanes
//  mX_dataLoad_o     out  32  load data, valid in the cycle mX_busy_o is low with mX_enable_i high
//  mX_busy_o         out  1   high while the request is pending; low in the completion cycle
//  devEnable_o       out  1   to devctrl
//  devWrite_o        out  1
//  devPhysicalAddr_o out  32
//  devDataSave_o     out  32
//  devByteSelect_o   out  4
//  devDataLoad_i     in   32  from devctrl
//  devBusy_i         in   1   from devctrl; transaction completes in the first owned cycle it is low
//  timeout_o         out  1   one-cycle pulse when the watchdog aborts
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, last=1 (m0 wins first tie), wdog=0, timeout_o=0, devEnable_o=0.
//  - States: IDLE, OWN.
//    - IDLE: if any mX_enable_i, owner <= chosen master, go OWN.
//      Tie: the master != last. devEnable_o=0 in IDLE.
//    - OWN: dev* outputs = owner's fields (combinational mux on registered owner).
//      Complete when devBusy_i==0 -> owner's busy_o=0, dataLoad_o=devDataLoad_i, last<=owner, go IDLE.
//  - Latency: request at cycle t -> devEnable_o at t+1.
//    Earliest completion at t+1 (busy_o low then), i.e. 2 cycles.
//  - Always one IDLE cycle (devEnable_o low) between transactions, so devices see a fresh enable edge.
//  - Non-owner with enable high: busy_o=1. Master with enable low: busy_o=0, dataLoad_o=0.
//  - Watchdog: wdog cleared on entering OWN; +1 each OWN cycle with devBusy_i high.
//    When wdog==TIMEOUT_CYCLES-1 and devBusy_i still high -> forced completion:
//    busy_o=0, dataLoad_o=TIMEOUT_DATA, timeout_o=1, go IDLE, last<=owner.
//    Width $clog2(TIMEOUT_CYCLES+1); never wraps.
//  - Owner drops enable mid-OWN (protocol violation): devEnable_o follows it low,
//    return IDLE next cycle, last unchanged, no timeout_o.
//  - Simultaneous completion and new request from the other master: completion first;
//    the other master is granted from the following IDLE cycle.
//  - rst_n low mid-OWN: immediate return to reset values; the device transaction is abandoned.
// STRUCTURE
//  - dev_arb_defs.vh: state encodings (IDLE/OWN) and default TIMEOUT_DATA; shared with the DMA engine.
//  - Sub-module dev_arb_watchdog (counter + abort compare). Rest is a single always block plus output muxes.
// TESTING
//  1. m0 load 0x80000000, devBusy_i low immediately -> devEnable_o at t+1, m0_busy_o low at t+1,
//     m0_dataLoad_o = devDataLoad_i.
//  2. m0 and m1 request in the same cycle, 3 rounds, busy 2 cycles each
//     -> grants m0, m1, m0, m1...; one devEnable_o-low cycle between each.
//  3. m1 store 0xA5A5A5A5, byteSelect 4'b0011, devBusy_i high 10 cycles
//     -> dev fields stable for all 11 cycles; m1_busy_o low only in the 11th.
//  4. TIMEOUT_CYCLES=8, devBusy_i stuck high -> after 8 OWN cycles m0_dataLoad_o=32'hDEADBEEF,
//     timeout_o single pulse, then m1 is granted.
//  5. rst_n asserted during OWN -> devEnable_o and timeout_o 0 asynchronously;
//     after release the first tie goes to m0.
//  6. Owner drops enable mid-OWN -> devEnable_o 0 the same cycle, IDLE next cycle, last unchanged.

Source files
------------

// File: rtl/dev_bus_arbiter_pkg.sv
// Shared types and constants for the two-master device bus arbiter.
// The state encoding and default abort data are also used by the DMA engine.
package dev_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BSEL_W = 4;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BSEL_W-1:0] bsel;
    } dev_req_t;

    // Counter width able to hold 0..cycles; a disabled watchdog still needs one bit.
    function automatic int unsigned wdog_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/dev_bus_arbiter_watchdog.sv
// Stall counter for the device bus: counts owned cycles with the device busy
// and flags the cycle in which the current transaction must be aborted.
module dev_bus_arbiter_watchdog
    import dev_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_stall,
    output logic o_abort_c
);

    localparam int unsigned WDOG_W = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] LIMIT =
        WDOG_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] r_wdog;

    // Saturates at LIMIT so it can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (i_clear) begin
            r_wdog <= '0;
        end else if (i_stall && (r_wdog != LIMIT)) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    assign o_abort_c = (TIMEOUT_CYCLES != 0) && i_stall && (r_wdog == LIMIT);

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing the devctrl request port between the CPU (m0)
// and the DMA engine (m1); each grant is held until the device completes.
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 4096,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_dataSave_i,
    input  logic [BSEL_W-1:0] m0_byteSelect_i,
    output logic [DATA_W-1:0] m0_dataLoad_o,
    output logic              m0_busy_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_dataSave_i,
    input  logic [BSEL_W-1:0] m1_byteSelect_i,
    output logic [DATA_W-1:0] m1_dataLoad_o,
    output logic              m1_busy_o,
    output logic              devEnable_o,
    output logic              devWrite_o,
    output logic [ADDR_W-1:0] devPhysicalAddr_o,
    output logic [DATA_W-1:0] devDataSave_o,
    output logic [BSEL_W-1:0] devByteSelect_o,
    input  logic [DATA_W-1:0] devDataLoad_i,
    input  logic              devBusy_i,
    output logic              timeout_o
);

    arb_state_t r_state, w_state_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_last,  w_last_nxt;

    logic [1:0]        w_en;
    logic [1:0]        w_busy;
    logic [DATA_W-1:0] w_load [2];
    dev_req_t          w_req  [2];
    dev_req_t          w_sel;
    logic              w_own_en;
    logic              w_abort;

    assign w_en     = {m1_enable_i, m0_enable_i};
    assign w_req[0] = {m0_write_i, m0_addr_i, m0_dataSave_i, m0_byteSelect_i};
    assign w_req[1] = {m1_write_i, m1_addr_i, m1_dataSave_i, m1_byteSelect_i};
    assign w_sel    = w_req[r_owner];
    assign w_own_en = w_en[r_owner];

    dev_bus_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == ST_IDLE),
        .i_stall   ((r_state == ST_OWN) && w_own_en && devBusy_i),
        .o_abort_c (w_abort)
    );

    // last=1 after reset so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_busy      = w_en;
        w_load[0]   = '0;
        w_load[1]   = '0;
        devEnable_o = 1'b0;
        timeout_o   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_en) begin
                    w_owner_nxt = (&w_en) ? ~r_last : w_en[1];
                    w_state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                devEnable_o = w_own_en;
                // An owner that abandons its request just releases the bus.
                if (!w_own_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (!devBusy_i) begin
                    w_busy[r_owner] = 1'b0;
                    w_load[r_owner] = devDataLoad_i;
                    w_last_nxt      = r_owner;
                    w_state_nxt     = ST_IDLE;
                end else if (w_abort) begin
                    w_busy[r_owner] = 1'b0;
                    w_load[r_owner] = TIMEOUT_DATA;
                    timeout_o       = 1'b1;
                    w_last_nxt      = r_owner;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign m0_busy_o         = w_busy[0];
    assign m1_busy_o         = w_busy[1];
    assign m0_dataLoad_o     = w_load[0];
    assign m1_dataLoad_o     = w_load[1];
    assign devWrite_o        = w_sel.write;
    assign devPhysicalAddr_o = w_sel.addr;
    assign devDataSave_o     = w_sel.data;
    assign devByteSelect_o   = w_sel.bsel;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of the arbitration rules.
module tb_dev_bus_arbiter;

    localparam int unsigned TO    = 12;
    localparam logic [31:0] TDATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_en   [2];
    logic        tb_wr   [2];
    logic [31:0] tb_addr [2];
    logic [31:0] tb_dsv  [2];
    logic [3:0]  tb_bs   [2];
    logic [31:0] m0_load, m1_load;
    logic        m0_busy, m1_busy;
    logic        devEnable_o, devWrite_o, timeout_o;
    logic [31:0] devPhysicalAddr_o, devDataSave_o;
    logic [3:0]  devByteSelect_o;
    logic [31:0] devDataLoad_i;
    logic        devBusy_i;

    int n_checks = 0;
    int n_fail   = 0;

    bit md_own;
    int md_owner, md_last, md_stall, md_cyc;
    bit done [2];
    int req_left [2];
    int dev_len;

    always #5 clk = ~clk;

    dev_bus_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (TDATA)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .m0_enable_i       (tb_en[0]),
        .m0_write_i        (tb_wr[0]),
        .m0_addr_i         (tb_addr[0]),
        .m0_dataSave_i     (tb_dsv[0]),
        .m0_byteSelect_i   (tb_bs[0]),
        .m0_dataLoad_o     (m0_load),
        .m0_busy_o         (m0_busy),
        .m1_enable_i       (tb_en[1]),
        .m1_write_i        (tb_wr[1]),
        .m1_addr_i         (tb_addr[1]),
        .m1_dataSave_i     (tb_dsv[1]),
        .m1_byteSelect_i   (tb_bs[1]),
        .m1_dataLoad_o     (m1_load),
        .m1_busy_o         (m1_busy),
        .devEnable_o       (devEnable_o),
        .devWrite_o        (devWrite_o),
        .devPhysicalAddr_o (devPhysicalAddr_o),
        .devDataSave_o     (devDataSave_o),
        .devByteSelect_o   (devByteSelect_o),
        .devDataLoad_i     (devDataLoad_i),
        .devBusy_i         (devBusy_i),
        .timeout_o         (timeout_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: one tenure per grant; ties go to the master that was not served last.
    always @(negedge clk) begin : model_blk
        logic        e_busy [2];
        logic [31:0] e_load [2];
        logic        e_den, e_to;
        bit          n_own;
        int          n_owner, n_last, n_stall, n_cyc, o;
        if (!rst_n) begin
            check_eq("rst_devEnable", 32'(devEnable_o), 32'd0);
            check_eq("rst_timeout", 32'(timeout_o), 32'd0);
            md_own = 0; md_owner = 0; md_last = 1; md_stall = 0; md_cyc = 0;
            done[0] = 0; done[1] = 0;
        end else begin
            e_busy[0] = tb_en[0]; e_busy[1] = tb_en[1];
            e_load[0] = '0;       e_load[1] = '0;
            e_den = 1'b0; e_to = 1'b0;
            n_own = md_own; n_owner = md_owner; n_last = md_last;
            n_stall = md_stall; n_cyc = md_cyc;
            if (!md_own) begin
                if (tb_en[0] || tb_en[1]) begin
                    n_own = 1;
                    n_owner = (tb_en[0] && tb_en[1]) ? 1 - md_last : (tb_en[1] ? 1 : 0);
                    n_stall = 0;
                    n_cyc = 0;
                end
            end else begin
                o = md_owner;
                e_den = tb_en[o];
                n_cyc = md_cyc + 1;
                check_eq("devWrite", 32'(devWrite_o), 32'(tb_wr[o]));
                check_eq("devAddr", devPhysicalAddr_o, tb_addr[o]);
                check_eq("devDataSave", devDataSave_o, tb_dsv[o]);
                check_eq("devByteSel", 32'(devByteSelect_o), 32'(tb_bs[o]));
                if (!tb_en[o]) begin
                    n_own = 0;
                end else if (!devBusy_i) begin
                    e_busy[o] = 1'b0; e_load[o] = devDataLoad_i;
                    n_last = o; n_own = 0; done[o] = 1;
                end else if (TO != 0 && md_stall + 1 == TO) begin
                    e_busy[o] = 1'b0; e_load[o] = TDATA; e_to = 1'b1;
                    n_last = o; n_own = 0; done[o] = 1;
                end else begin
                    n_stall = md_stall + 1;
                end
            end
            check_eq("devEnable", 32'(devEnable_o), 32'(e_den));
            check_eq("timeout", 32'(timeout_o), 32'(e_to));
            check_eq("m0_busy", 32'(m0_busy), 32'(e_busy[0]));
            check_eq("m1_busy", 32'(m1_busy), 32'(e_busy[1]));
            check_eq("m0_dataLoad", m0_load, e_load[0]);
            check_eq("m1_dataLoad", m1_load, e_load[1]);
            md_own = n_own; md_owner = n_owner; md_last = n_last;
            md_stall = n_stall; md_cyc = n_cyc;
        end
    end

    task automatic new_req(input int i);
        tb_en[i]   = 1'b1;
        tb_wr[i]   = 1'($urandom);
        tb_addr[i] = $urandom;
        tb_dsv[i]  = $urandom;
        tb_bs[i]   = 4'($urandom);
    endtask

    // Device is busy for the first dev_len owned cycles of each tenure.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
                done[i] = 0;
                if (req_left[i] > 0) begin
                    req_left[i]--;
                    new_req(i);
                end else begin
                    tb_en[i] = 1'b0;
                end
            end
        end
        devBusy_i     = md_own && (md_cyc < dev_len);
        devDataLoad_i = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((tb_en[0] || tb_en[1]) && k < budget) begin
            cycle();
            k++;
        end
        check_eq("drain", 32'({tb_en[0], tb_en[1]}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            tb_en[i] = 0; tb_wr[i] = 0; tb_addr[i] = 0; tb_dsv[i] = 0; tb_bs[i] = 0;
            req_left[i] = 0;
        end
        devBusy_i = 0; devDataLoad_i = 0; dev_len = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single m0 load with an immediately ready device.
        tb_en[0] = 1; tb_wr[0] = 0; tb_addr[0] = 32'h8000_0000;
        tb_dsv[0] = 32'h0; tb_bs[0] = 4'hF;
        wait_idle(20);

        // Both masters contend for three rounds, device busy 2 cycles each.
        dev_len = 2; req_left[0] = 2; req_left[1] = 2;
        new_req(0); new_req(1);
        wait_idle(100);

        // m1 store held through 10 busy cycles.
        dev_len = 10;
        tb_en[1] = 1; tb_wr[1] = 1; tb_addr[1] = 32'h1000_0040;
        tb_dsv[1] = 32'hA5A5A5A5; tb_bs[1] = 4'b0011;
        wait_idle(40);

        // Stuck device: m0 aborted by the watchdog, then m1 is served.
        dev_len = 1000;
        new_req(0); new_req(1);
        for (int k = 0; k < 60 && tb_en[0]; k++) cycle();
        check_eq("m0_aborted", 32'(tb_en[0]), 32'd0);
        dev_len = 1;
        wait_idle(40);

        // Owner withdraws mid-tenure; next tie still honours the previous winner.
        dev_len = 6;
        new_req(0);
        repeat (3) cycle();
        tb_en[0] = 1'b0;
        cycle();
        dev_len = 0;
        new_req(0); new_req(1);
        wait_idle(40);

        // Asynchronous reset during a tenure.
        dev_len = 6;
        new_req(0);
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_devEnable", 32'(devEnable_o), 32'd0);
        check_eq("async_rst_timeout", 32'(timeout_o), 32'd0);
        tb_en[0] = 0; tb_en[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dev_len = 0;
        new_req(0); new_req(1);
        @(negedge clk);
        @(negedge clk);
        check_eq("post_rst_tie_m0", devPhysicalAddr_o, tb_addr[0]);
        wait_idle(40);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (!tb_en[i] && ($urandom % 3 == 0)) new_req(i);
                else if (tb_en[i] && ($urandom % 80 == 0)) tb_en[i] = 1'b0;
            end
            if (!md_own) begin
                case ($urandom % 10)
                    0:       dev_len = 30;
                    1, 2:    dev_len = 4 + int'($urandom % 7);
                    default: dev_len = int'($urandom % 4);
                endcase
            end
        end
        req_left[0] = 0; req_left[1] = 0;
        dev_len = 0;
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
